// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the skid entry record used by the IF->ID stage.
package pipe_pkg;

   localparam logic [31:0] NOP_INST_DEF = 32'h02800000;
   localparam logic [31:0] RESET_PC_DEF = 32'h1bfffffc;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        cancelled;
   } skid_entry_t;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// Handshake bundle between an upstream stage, the skid stage and the downstream stage.
interface pipe_skid_stage_if #(
   parameter int PC_W   = 32,
   parameter int INST_W = 32,
   parameter int DEPTH  = 2
);
   logic                       in_valid;
   logic                       in_ready;
   logic [PC_W-1:0]            in_pc;
   logic [INST_W-1:0]          in_inst;
   logic                       in_cancel;
   logic                       flush;
   logic                       out_valid;
   logic                       out_ready;
   logic [PC_W-1:0]            out_pc;
   logic [INST_W-1:0]          out_inst;
   logic                       out_cancelled;
   logic [$clog2(DEPTH):0]     occupancy;

   // stage side
   modport slave (
      input  in_valid, in_pc, in_inst, in_cancel, flush, out_ready,
      output in_ready, out_valid, out_pc, out_inst, out_cancelled, occupancy
   );

   // environment side (upstream producer + downstream consumer)
   modport master (
      output in_valid, in_pc, in_inst, in_cancel, flush, out_ready,
      input  in_ready, out_valid, out_pc, out_inst, out_cancelled, occupancy
   );
endinterface

// File: rtl/pipe_skid_ram.sv
// DEPTH-entry skid storage: one synchronous write port, one asynchronous read port.
module pipe_skid_ram
   import pipe_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  skid_entry_t   wdata,
   input  logic [AW-1:0] raddr,
   output skid_entry_t   rdata
);

   // contents are don't-care after reset/flush, so no reset on the array
   skid_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a DEPTH-entry skid FIFO, cancel-to-NOP and flush.
// Optional perf counters (stall_cnt, full_cnt) when PIPE_SKID_PERF_EN is defined.
module pipe_skid_stage
   import pipe_pkg::*;
#(
   parameter int                 PC_W     = 32,
   parameter int                 INST_W   = 32,
   parameter int                 DEPTH    = 2,
   parameter logic [INST_W-1:0]  NOP_INST = INST_W'(NOP_INST_DEF),
   parameter logic [PC_W-1:0]    RESET_PC = PC_W'(RESET_PC_DEF)
) (
   input  logic                  clk,
   input  logic                  rst,
`ifdef PIPE_SKID_PERF_EN
   output logic [31:0]           stall_cnt,
   output logic [31:0]           full_cnt,
`endif
   pipe_skid_stage_if.slave      bus
);

   localparam int             AW   = $clog2(DEPTH);
   localparam int             CW   = AW + 1;
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);

   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          empty;
   logic          push;
   logic          pop;
   skid_entry_t   wr_entry;
   skid_entry_t   rd_entry;

   // handshake terms come only from registered count, never from out_ready
   assign empty        = (count == '0);
   assign bus.in_ready = (count != FULL);
   assign bus.out_valid = !empty;
   assign push         = bus.in_valid && bus.in_ready;
   assign pop          = bus.out_valid && bus.out_ready;

   always_comb begin
      wr_entry.pc        = 32'(bus.in_pc);
      wr_entry.inst      = bus.in_cancel ? 32'(NOP_INST) : 32'(bus.in_inst);
      wr_entry.cancelled = bus.in_cancel;
   end

   pipe_skid_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (push && !bus.flush),
      .waddr (wr_ptr),
      .wdata (wr_entry),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );

   // flush wins over push/pop; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign bus.out_pc        = empty ? RESET_PC : PC_W'(rd_entry.pc);
   assign bus.out_inst      = empty ? NOP_INST : INST_W'(rd_entry.inst);
   assign bus.out_cancelled = empty ? 1'b0     : rd_entry.cancelled;
   assign bus.occupancy     = count;

`ifdef PIPE_SKID_PERF_EN
   // counters survive flush; only rst clears them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         full_cnt  <= '0;
      end else begin
         if (bus.out_valid && !bus.out_ready) stall_cnt <= stall_cnt + 32'd1;
         if (count == FULL)                   full_cnt  <= full_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed vector table, hand sequences, random vs queue model.
module tb_pipe_skid_stage;

   localparam int          DEPTH = 2;
   localparam logic [31:0] NOP   = 32'h02800000;
   localparam logic [31:0] RPC   = 32'h1bfffffc;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   pipe_skid_stage_if #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH)) bus ();

`ifdef PIPE_SKID_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] full_cnt;
`endif

   pipe_skid_stage #(.PC_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
`ifdef PIPE_SKID_PERF_EN
      .stall_cnt (stall_cnt),
      .full_cnt  (full_cnt),
`endif
      .bus       (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        cancelled;
   } ent_t;

   ent_t q[$];

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [31:0] inst;
      logic        c;
      logic        f;
      logic        r;
      logic        e_valid;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_canc;
      logic        e_ready;
      logic [31:0] e_occ;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic c, input logic f, input logic r);
      bus.in_valid  = v;
      bus.in_pc     = pc;
      bus.in_inst   = inst;
      bus.in_cancel = c;
      bus.flush     = f;
      bus.out_ready = r;
   endtask

   // reference: FIFO of accepted records, rules taken straight from the handshake definition
   task automatic model_edge(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                             input logic c, input logic f, input logic r);
      bit do_push, do_pop;
      ent_t e;
      if (f) begin
         q.delete();
      end else begin
         do_push = v && (q.size() < DEPTH);
         do_pop  = r && (q.size() > 0);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.pc = pc;
            e.inst = c ? NOP : inst;
            e.cancelled = c;
            q.push_back(e);
         end
      end
   endtask

   task automatic check_model(input string tag);
      bit has;
      has = (q.size() != 0);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(has));
      check({tag, ".out_pc"}, bus.out_pc, has ? q[0].pc : RPC);
      check({tag, ".out_inst"}, bus.out_inst, has ? q[0].inst : NOP);
      check({tag, ".out_cancelled"}, 32'(bus.out_cancelled), has ? 32'(q[0].cancelled) : 32'd0);
      check({tag, ".in_ready"}, 32'(bus.in_ready), 32'(q.size() != DEPTH));
      check({tag, ".occupancy"}, 32'(bus.occupancy), 32'(q.size()));
   endtask

   // one clock: drive at negedge, let the edge happen, sample at next negedge
   task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                        input logic c, input logic f, input logic r, input string tag);
      drive(v, pc, inst, c, f, r);
      @(posedge clk);
      model_edge(v, pc, inst, c, f, r);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_reset();
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
   endtask

   vec_t vecs[13];

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      @(negedge clk);
      do_reset();

      check("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("rst.out_pc", bus.out_pc, 32'h1bfffffc);
      check("rst.out_inst", bus.out_inst, 32'h02800000);
      check("rst.out_cancelled", 32'(bus.out_cancelled), 32'd0);
      check("rst.in_ready", 32'(bus.in_ready), 32'd1);
      check("rst.occupancy", 32'(bus.occupancy), 32'd0);

      //          v  pc            inst          c  f  r   valid pc            inst          canc rdy occ
      vecs[0]  = '{1, 32'h1c000000, 32'h11111111, 0, 0, 0,  1, 32'h1c000000, 32'h11111111, 0, 1, 1};
      vecs[1]  = '{1, 32'h1c000004, 32'h22222222, 0, 0, 0,  1, 32'h1c000000, 32'h11111111, 0, 0, 2};
      vecs[2]  = '{1, 32'h1c000008, 32'h33333333, 1, 0, 0,  1, 32'h1c000000, 32'h11111111, 0, 0, 2};
      vecs[3]  = '{0, 32'h0,        32'h0,        0, 0, 1,  1, 32'h1c000004, 32'h22222222, 0, 1, 1};
      vecs[4]  = '{0, 32'h0,        32'h0,        0, 0, 1,  0, RPC,          NOP,          0, 1, 0};
      vecs[5]  = '{0, 32'h0,        32'h0,        0, 0, 1,  0, RPC,          NOP,          0, 1, 0};
      vecs[6]  = '{1, 32'h1c000010, 32'h00150004, 1, 0, 0,  1, 32'h1c000010, NOP,          1, 1, 1};
      vecs[7]  = '{1, 32'h1c000014, 32'h44444444, 0, 0, 0,  1, 32'h1c000010, NOP,          1, 0, 2};
      vecs[8]  = '{1, 32'h1c000018, 32'h55555555, 0, 1, 1,  0, RPC,          NOP,          0, 1, 0};
      vecs[9]  = '{1, 32'h1c000020, 32'h66666666, 0, 0, 0,  1, 32'h1c000020, 32'h66666666, 0, 1, 1};
      vecs[10] = '{1, 32'h1c000024, 32'h77777777, 0, 1, 1,  0, RPC,          NOP,          0, 1, 0};
      vecs[11] = '{1, 32'h1c000028, 32'h88888888, 0, 0, 0,  1, 32'h1c000028, 32'h88888888, 0, 1, 1};
      vecs[12] = '{0, 32'h0,        32'h0,        0, 0, 1,  0, RPC,          NOP,          0, 1, 0};

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].c, vecs[i].f, vecs[i].r);
         @(posedge clk);
         model_edge(vecs[i].v, vecs[i].pc, vecs[i].inst, vecs[i].c, vecs[i].f, vecs[i].r);
         @(negedge clk);
         check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_valid));
         check($sformatf("vec%0d.out_pc", i), bus.out_pc, vecs[i].e_pc);
         check($sformatf("vec%0d.out_inst", i), bus.out_inst, vecs[i].e_inst);
         check($sformatf("vec%0d.out_cancelled", i), 32'(bus.out_cancelled), 32'(vecs[i].e_canc));
         check($sformatf("vec%0d.in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ready));
         check($sformatf("vec%0d.occupancy", i), 32'(bus.occupancy), vecs[i].e_occ);
      end

      // streaming: one in, one out per cycle, occupancy pinned at 1
      cycle(1'b1, 32'h1c001000, 32'hA0000000, 1'b0, 1'b0, 1'b1, "stream0");
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b1, 32'h1c001000 + 32'(4 * k), 32'hA0000000 + 32'(k), 1'b0, 1'b0, 1'b1, "stream");
         check("stream.occ1", 32'(bus.occupancy), 32'd1);
         check("stream.head_pc", bus.out_pc, 32'h1c001000 + 32'(4 * k));
      end
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, "stream_drain");

      // reset asserted mid-operation empties the stage before any clock edge
      cycle(1'b1, 32'h1c002000, 32'h1, 1'b0, 1'b0, 1'b0, "pre_rst0");
      cycle(1'b1, 32'h1c002004, 32'h2, 1'b0, 1'b0, 1'b0, "pre_rst1");
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst.out_valid", 32'(bus.out_valid), 32'd0);
      check("async_rst.occupancy", 32'(bus.occupancy), 32'd0);
      check("async_rst.out_pc", bus.out_pc, RPC);
      @(negedge clk);
      rst = 1'b0;
      q.delete();

      for (int k = 0; k < 2000; k++) begin
         cycle(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 4) == 0,
               ($urandom % 32) == 0, ($urandom % 3) != 0, "rand");
      end

`ifdef PIPE_SKID_PERF_EN
      do_reset();
      check("perf.rst_stall", stall_cnt, 32'd0);
      check("perf.rst_full", full_cnt, 32'd0);
      cycle(1'b1, 32'h1c003000, 32'h9, 1'b0, 1'b0, 1'b0, "perf_push");
      repeat (5) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "perf_stall");
      check("perf.stall5", stall_cnt, 32'd5);
      check("perf.full0", full_cnt, 32'd0);
      cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, "perf_flush");
      check("perf.stall_after_flush", stall_cnt, 32'd5);
      cycle(1'b1, 32'h1c003004, 32'hA, 1'b0, 1'b0, 1'b0, "perf_f0");
      cycle(1'b1, 32'h1c003008, 32'hB, 1'b0, 1'b0, 1'b0, "perf_f1");
      cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, "perf_f2");
      check("perf.full1", full_cnt, 32'd1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
